// File: rtl/generador_patching.sv
// generador_patching: per-index activation cache; emits patch bit when the cached value is within UMBRAL
module generador_patching #(
   parameter int N      = 16,
   parameter int DEPTH  = 16,
   parameter int UMBRAL = 4
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     in_valid,
   output logic                     in_ready,
   input  logic [N-1:0]             in_a,
   input  logic [$clog2(DEPTH)-1:0] in_idx,
   input  logic                     flush,
   output logic                     out_valid,
   input  logic                     out_ready,
   output logic [N-1:0]             a_org,
   output logic [N-1:0]             a_cache,
   output logic                     p,
   output logic [$clog2(DEPTH)-1:0] out_idx,
   output logic [15:0]              cnt_patch
);
   logic [N-1:0]     cache [DEPTH];
   logic [DEPTH-1:0] valid;
   logic [N-1:0]     e;
   logic [N:0]       d, diff;
   logic             accept, hit;

   assign in_ready = !out_valid || out_ready;
   assign accept   = in_valid && in_ready;
   assign e        = cache[in_idx];
   // subtraction in N+1 bits cannot overflow, so the magnitude is exact
   assign d        = {in_a[N-1], in_a} - {e[N-1], e};
   assign diff     = d[N] ? ~d + 1'b1 : d;
   // a flush in the same cycle hides every entry from the lookup
   assign hit      = valid[in_idx] && !flush && diff <= (N+1)'(UMBRAL);

   // cache data: refreshed on every accepted miss, contents after reset are irrelevant
   always_ff @(posedge clk)
      if (accept && !hit) cache[in_idx] <= in_a;

   // valid bits: flush clears all but a simultaneous miss write, otherwise misses mark their slot
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) valid <= '0;
      else if (flush) valid <= accept ? DEPTH'(1) << in_idx : '0;
      else if (accept && !hit) valid[in_idx] <= 1'b1;

   // output register and saturating patch counter
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         out_valid <= 1'b0;
         p         <= 1'b0;
         a_org     <= '0;
         a_cache   <= '0;
         out_idx   <= '0;
         cnt_patch <= '0;
      end else if (accept) begin
         out_valid <= 1'b1;
         p         <= hit;
         a_org     <= in_a;
         a_cache   <= hit ? e : in_a;
         out_idx   <= in_idx;
         if (hit && cnt_patch != 16'hFFFF) cnt_patch <= cnt_patch + 1'b1;
      end else if (out_ready) out_valid <= 1'b0;
endmodule

// File: tb/tb_generador_patching.sv
// tb_generador_patching: randomized and directed checks against a behavioural cache model
module tb_generador_patching;
   localparam int N = 16, DEPTH = 16, UMBRAL = 4;
   logic          clk = 0, rst_n = 0, in_valid = 0, flush = 0, out_ready = 1;
   logic [N-1:0]  in_a = '0;
   logic [3:0]    in_idx = '0;
   logic          in_ready, out_valid, p;
   logic [N-1:0]  a_org, a_cache;
   logic [3:0]    out_idx;
   logic [15:0]   cnt_patch;
   logic [37:0]   obs, last_ex;
   logic [N-1:0]  mcache [DEPTH];
   bit            mvalid [DEPTH];
   int            mcnt = 0;
   int            checks = 0, errors = 0;

   generador_patching #(.N(N), .DEPTH(DEPTH), .UMBRAL(UMBRAL)) dut (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .in_a(in_a),
      .in_idx(in_idx), .flush(flush), .out_valid(out_valid), .out_ready(out_ready),
      .a_org(a_org), .a_cache(a_cache), .p(p), .out_idx(out_idx), .cnt_patch(cnt_patch)
   );

   assign obs = {out_valid, p, a_org, a_cache, out_idx};
   always #5 clk = ~clk;

   task automatic model_reset();
      foreach (mvalid[i]) begin
         mvalid[i] = 0;
         mcache[i] = '0;
      end
      mcnt = 0;
   endtask

   task automatic model(input logic [3:0] idx, input logic [N-1:0] a, input bit fl, output logic [37:0] ex);
      int da;
      bit h;
      da = int'($signed(a)) - int'($signed(mcache[idx]));
      if (da < 0) da = -da;
      h = mvalid[idx] && !fl && da <= UMBRAL;
      ex = {1'b1, h, a, h ? mcache[idx] : a, idx};
      if (fl) foreach (mvalid[i]) mvalid[i] = 0;
      if (!h) begin
         mcache[idx] = a;
         mvalid[idx] = 1;
      end
      if (h && mcnt < 65535) mcnt++;
   endtask

   task automatic beat(input logic [3:0] idx, input logic [N-1:0] a, input bit fl);
      logic [37:0] ex;
      @(negedge clk);
      in_valid = 1; in_idx = idx; in_a = a; flush = fl; out_ready = 1;
      model(idx, a, fl, ex);
      @(posedge clk);
      #1 in_valid = 0; flush = 0;
      last_ex = ex;
      checks++;
      if (obs !== ex) begin
         errors++;
         $display("FAIL beat idx=%0d a=%h fl=%0d: got v/p/org/cache/idx %h expected %h", idx, a, fl, obs, ex);
      end
      checks++;
      if (cnt_patch !== 16'(mcnt)) begin
         errors++;
         $display("FAIL cnt_patch after idx=%0d a=%h: got %0d expected %0d", idx, a, cnt_patch, mcnt);
      end
   endtask

   task automatic test_reset();
      model_reset();
      #12;
      checks++;
      if ({obs, cnt_patch, in_ready} !== {38'd0, 16'd0, 1'b1}) begin
         errors++;
         $display("FAIL reset: got %h/%h/%b expected zeros with in_ready=1", obs, cnt_patch, in_ready);
      end
      @(negedge clk) rst_n = 1;
   endtask

   task automatic test_cold();
      beat(3, 16'd100, 0);
      beat(3, 16'd103, 0);
   endtask

   task automatic test_threshold();
      beat(3, 16'd104, 0);
      beat(3, 16'd105, 0);
      beat(3, 16'd101, 0);
   endtask

   task automatic test_signed_wrap();
      beat(0, 16'h7FFF, 0);
      beat(0, 16'h8000, 0);
      beat(1, 16'hFFFE, 0);
      beat(1, 16'h0001, 0);
   endtask

   task automatic test_back_to_back();
      logic [37:0] ea, eb;
      logic [3:0]  ix;
      logic [N-1:0] aa, ab;
      ix = 4'($urandom_range(0, 15));
      aa = mcache[ix] + 16'($urandom_range(0, 8)) - 16'd4;
      ab = aa + 16'($urandom_range(0, 10)) - 16'd5;
      @(negedge clk);
      in_valid = 1; in_idx = ix; in_a = aa; out_ready = 1;
      model(ix, aa, 0, ea);
      @(posedge clk);
      #1 in_a = ab; out_ready = 0;
      repeat (3) begin
         @(negedge clk);
         checks++;
         if (in_ready !== 1'b0) begin
            errors++;
            $display("FAIL stall in_ready: got %b expected 0", in_ready);
         end
         checks++;
         if (obs !== ea) begin
            errors++;
            $display("FAIL stall hold: got %h expected %h", obs, ea);
         end
         checks++;
         if (cnt_patch !== 16'(mcnt)) begin
            errors++;
            $display("FAIL stall cnt: got %0d expected %0d", cnt_patch, mcnt);
         end
      end
      out_ready = 1;
      model(ix, ab, 0, eb);
      @(posedge clk);
      #1 in_valid = 0;
      checks++;
      if (obs !== eb) begin
         errors++;
         $display("FAIL release second beat: got %h expected %h", obs, eb);
      end
      @(posedge clk);
      #1 checks++;
      if (out_valid !== 1'b0) begin
         errors++;
         $display("FAIL release duplicate: got out_valid %b expected 0", out_valid);
      end
   endtask

   task automatic test_flush();
      beat(2, 16'd50, 0);
      beat(5, 16'd60, 0);
      beat(2, 16'd51, 1);
      beat(2, 16'd51, 0);
      beat(5, 16'd60, 0);
      beat(6, 16'd70, 0);
      @(negedge clk);
      out_ready = 0; flush = 1;
      foreach (mvalid[i]) mvalid[i] = 0;
      @(posedge clk);
      #1 flush = 0;
      checks++;
      if ({obs, cnt_patch} !== {last_ex, 16'(mcnt)}) begin
         errors++;
         $display("FAIL idle flush output: got %h/%0d expected %h/%0d", obs, cnt_patch, last_ex, mcnt);
      end
      beat(6, 16'd70, 0);
   endtask

   task automatic test_random();
      logic [3:0] ix;
      logic [N-1:0] a;
      repeat (400) begin
         ix = 4'($urandom_range(0, 15));
         a = ($urandom_range(0, 3) == 0) ? 16'($urandom) : mcache[ix] + 16'($urandom_range(0, 12)) - 16'd6;
         beat(ix, a, $urandom_range(0, 19) == 0);
      end
   endtask

   task automatic test_async_reset();
      beat(4, 16'd200, 0);
      @(negedge clk);
      out_ready = 0;
      #1 rst_n = 0;
      model_reset();
      #1 checks++;
      if ({out_valid, p, a_org, a_cache, cnt_patch} !== '0) begin
         errors++;
         $display("FAIL async reset: got v=%b p=%b org=%h cache=%h cnt=%0d expected all zero", out_valid, p, a_org, a_cache, cnt_patch);
      end
      @(negedge clk) rst_n = 1;
      beat(3, 16'd100, 0);
      beat(4, 16'd200, 0);
   endtask

   task automatic test_saturation();
      beat(7, 16'd1000, 0);
      @(negedge clk);
      in_valid = 1; in_idx = 7; in_a = 16'd1002; out_ready = 1;
      repeat (65537) @(posedge clk);
      #1 in_valid = 0;
      mcnt = 65535;
      checks++;
      if ({cnt_patch, p, a_cache} !== {16'hFFFF, 1'b1, 16'd1000}) begin
         errors++;
         $display("FAIL saturation: got cnt=%h p=%b cache=%0d expected FFFF 1 1000", cnt_patch, p, a_cache);
      end
      beat(7, 16'd999, 0);
   endtask

   initial begin
      test_reset();
      test_cold();
      test_threshold();
      test_signed_wrap();
      test_back_to_back();
      test_flush();
      test_random();
      test_async_reset();
      test_saturation();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule

// File: doc/generador_patching.md
Name: generador_patching

Overview:
Producer side of the activation-patching path. It receives a stream of indexed activations and compares each one against a per-index cache of previously sent activations. If the cached value is close enough, it emits patch bit p=1 together with the cached value. Otherwise it emits p=0 and refreshes the cache. Its outputs (a_org, a_cache, p) drive the patching mux stage directly.

Parameters:
N, 16, activation width (signed two's complement)
DEPTH, 16, number of cache entries; power of two, >=2
UMBRAL, 4, max |a - cached| (inclusive) for which patching is allowed; 0 <= UMBRAL < 2^(N-1)

Ports:
clk  input  1  clock, rising edge
rst_n  input  1  asynchronous active-low reset
in_valid  input  1  input activation valid
in_ready  output  1  block can accept input
in_a  input  N  incoming activation
in_idx  input  $clog2(DEPTH)  cache slot (neuron index)
flush  input  1  invalidate all cache entries
out_valid  output  1  output beat valid
out_ready  input  1  downstream accepts output
a_org  output  N  the activation as received
a_cache  output  N  cached activation used for patching
p  output  1  1 = downstream must use a_cache
out_idx  output  $clog2(DEPTH)  index of the output beat
cnt_patch  output  16  number of beats emitted with p=1, saturating

Behaviour:
- Reset (rst_n=0, asynchronous):
  - out_valid=0, p=0, a_org=0, a_cache=0, out_idx=0, cnt_patch=0.
  - All cache valid bits are cleared. Cache data is don't-care.
- Handshake:
  - Input is accepted when in_valid && in_ready.
  - Output beat completes when out_valid && out_ready.
  - in_ready = !out_valid || out_ready (combinational). Single output register, no skid buffer.
  - Outputs hold stable while out_valid && !out_ready.
- Latency: 1 cycle. An input accepted at edge k is presented with out_valid=1 after edge k. With out_ready=1 the block sustains 1 beat/cycle.
- Decision on accept, for e = cache[in_idx] and v = valid[in_idx]:
  - diff = sign-extend in_a and e to N+1 bits, subtract, take the absolute value in N+1 bits (no overflow).
  - Hit: v && diff <= UMBRAL.
    - p=1, a_cache=e, a_org=in_a.
    - Cache entry is unchanged.
    - cnt_patch increments by 1, holding at 0xFFFF.
  - Miss:
    - p=0, a_cache=in_a, a_org=in_a.
    - cache[in_idx] <= in_a and valid[in_idx] <= 1.
  - out_idx = in_idx.
  - The comparison uses the cached value, not the last emitted a_org. Drift across repeated hits is therefore bounded by UMBRAL.
- Back-to-back to the same index: the cache write happens on the accept edge, so the next accept to that index sees the updated entry. No stall or forwarding is required.
- Flush:
  - Without accept in the same cycle: all valid bits are cleared at the next edge. The output register and cnt_patch are unaffected.
  - With accept in the same cycle: the lookup is forced to a miss (p=0). After the edge, only valid[in_idx] is set, holding in_a; all other valid bits are clear.
- No accept (in_valid=0, or in_ready=0): no cache or counter change.
- Out-of-range indices cannot occur because DEPTH is a power of two.
- Reset mid-stream: any pending output beat is dropped (out_valid=0). The next beat after reset is a miss for every index.
- Implementation: cache data in a register array, one write port, one combinational read port.

Test Plan:
- Cold start, UMBRAL=4: send (idx3, 100) -> out p=0, a_org=a_cache=100, cnt_patch=0. Then (idx3, 103) -> p=1, a_cache=100, a_org=103, cnt_patch=1.
- Threshold boundary on a cache holding 100 at idx3: (idx3, 104) -> p=1. (idx3, 105) -> p=0, cache becomes 105. Then (idx3, 101) -> p=1 with a_cache=105.
- Signed wrap, N=16: cache idx0=0x7FFF, send 0x8000 -> diff=65535 in 17 bits, p=0. Cache idx1=-2 (0xFFFE), send 1 -> diff=3, p=1.
- Backpressure: hold out_ready=0 for 3 cycles with in_valid=1 -> in_ready=0, outputs stable, no cache or counter change. Release -> beats emerge in order, none lost or duplicated.
- Flush: prime idx2=50, idx5=60, then flush together with accept (idx2, 51) -> p=0. Then (idx2, 51) -> p=1 and (idx5, 60) -> p=0.
- Async reset with out_valid=1 and out_ready=0 -> out_valid=0 and cnt_patch=0 immediately. Next (idx3, 100) -> p=0.
- Saturation: force 65537 hits -> cnt_patch=0xFFFF.
